gpio_pad_ctrl: RTL and testbench
================================

GPIO_PAD_CTRL -- requirements
Module: gpio_pad_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 8: number of pad channels, range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, range 2..4.
REQ-003 SHALL have parameter DB_W, default 8: debounce counter width, range 1..16.
REQ-004 SHALL have port CLK_I, input, 1 bit: the single clock; all state is rising-edge.
REQ-005 SHALL have port RST_NI, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port MODE_I, input, 2*N_CH bits, one field per channel: 00 input-only, 01 push-pull, 10 open-drain (sink only), 11 open-source (source only).
REQ-007 SHALL have port DOUT_I, input, N_CH bits: output data per channel.
REQ-008 SHALL have port IE_EN_I, input, N_CH bits: input receiver enable.
REQ-009 SHALL have port PULL_I, input, 2*N_CH bits: {PU,PD} per channel, passed to the pad.
REQ-010 SHALL have port DB_EN_I, input, N_CH bits: debounce enable.
REQ-011 SHALL have port DB_LIMIT_I, input, DB_W bits: stable-cycle threshold, shared by all channels.
REQ-012 SHALL have port IRQ_EDGE_I, input, 2*N_CH bits: {fall,rise} interrupt enables per channel.
REQ-013 SHALL have port IRQ_CLR_I, input, N_CH bits: single-cycle clear of the pending bit.
REQ-014 SHALL have pad-side outputs, each N_CH bits: PAD_DO_O, PAD_OE_O, PAD_ODP_O, PAD_ODN_O, PAD_IE_O, PAD_PU_O, PAD_PD_O.
REQ-015 SHALL have port PAD_DI_I, input, N_CH bits: pad receiver output, asynchronous to CLK_I.
REQ-016 SHALL have outputs DIN_O (N_CH), IRQ_PEND_O (N_CH) and IRQ_O (1).

Function
REQ-017 SHALL register every PAD_*_O output, giving 1 cycle latency from the control inputs.
REQ-018 SHALL drive the pad controls per mode:
  - input-only: OE=0.
  - push-pull: OE=1, ODP=0, ODN=0.
  - open-drain: OE=1, ODP=1, ODN=0.
  - open-source: OE=1, ODP=0, ODN=1.
REQ-019 SHALL set PAD_DO_O = DOUT_I in every mode.
REQ-020 SHALL apply break-before-make when a channel's MODE_I changes between two driving modes: PAD_OE_O=0 for exactly 1 cycle, then the new ODP/ODN/OE take effect together.
REQ-021 SHALL drop PAD_OE_O with the normal 1-cycle latency, with no extra cycle, when a channel changes from a driving mode to input-only.
REQ-022 SHALL set PAD_IE_O=IE_EN_I and {PAD_PU_O,PAD_PD_O}=PULL_I, registered.
REQ-023 SHALL pass PAD_DI_I through a SYNC_STAGES-deep flop chain per channel, reset to 0.
REQ-024 SHALL, when DB_EN=0, copy the synchronised value to the filtered value on the next cycle.
REQ-025 SHALL, when DB_EN=1 and the synchronised value differs from the filtered value, increment the counter each cycle; the filtered value takes the new value, and the counter clears, in the cycle the count reaches DB_LIMIT_I.
REQ-026 SHALL clear the counter immediately if the synchronised value returns to the filtered value before the threshold.
REQ-027 SHALL treat DB_LIMIT_I=0 as DB_EN=0 and saturate the counter at all-ones.
REQ-028 SHALL, when IE_EN_I=0, force the synchroniser and filtered value to 0 and clear the counter; the forced 0 SHALL NOT raise a fall interrupt, including on the transition out of IE_EN_I=1.
REQ-029 SHALL set DIN_O = filtered value.
REQ-030 SHALL detect rise/fall edges on the filtered value; an enabled edge sets IRQ_PEND_O, which stays set until IRQ_CLR_I.
REQ-031 SHALL give set priority over a simultaneous IRQ_CLR_I, leaving the pending bit at 1.
REQ-032 SHALL make IRQ_O the registered OR of IRQ_PEND_O.
REQ-033 SHALL NOT change IRQ_PEND_O when IRQ_EDGE_I changes; a disabled edge is discarded, not latched.

Reset
REQ-034 SHALL, while RST_NI=0, force all outputs, synchronisers, counters, filtered values and pending bits to 0 immediately; with OE=0 all pads are input.
REQ-035 SHALL apply the first MODE_I on the second rising edge after deassertion, with no break-before-make cycle.
REQ-036 SHALL abort any debounce count in progress when reset is asserted mid-count; no edge results.

Verification
REQ-037 SHALL cover: ch0 mode 00->01 with DOUT=1 -> PAD_OE_O[0]=1, PAD_ODP/ODN=0 one cycle later.
REQ-038 SHALL cover: ch1 mode 01->10 -> PAD_OE_O[1]=0 for exactly one cycle, then OE=1, ODP=1.
REQ-039 SHALL cover: DB_EN=1, DB_LIMIT=4, PAD_DI 0->1 held 3 cycles then 0 -> DIN_O stays 0; held 6 cycles -> DIN_O=1 after SYNC_STAGES+4 cycles.
REQ-040 SHALL cover: rise enabled, ch2 rises -> IRQ_PEND_O[2]=1 and IRQ_O=1 next cycle; IRQ_CLR_I on the same cycle as a new rise -> pending stays 1.
REQ-041 SHALL cover: IE_EN 1->0 while DIN=1 with fall enabled -> DIN_O=0, IRQ_PEND_O unchanged.
REQ-042 SHALL cover: RST_NI low mid-debounce with the pad at 1 -> all outputs 0 asynchronously; after release DIN_O=1 after SYNC_STAGES+DB_LIMIT+1 cycles, with no stale count.

Source files
------------

// File: rtl/gpio_pad_ctrl.sv
// Per-channel GPIO pad control: mode decode with break-before-make on the drive side,
// synchronised and debounced receive path, and latched edge interrupts.
module gpio_pad_ctrl #(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_W        = 8
) (
    input  logic              CLK_I,
    input  logic              RST_NI,
    input  logic [2*N_CH-1:0] MODE_I,
    input  logic [N_CH-1:0]   DOUT_I,
    input  logic [N_CH-1:0]   IE_EN_I,
    input  logic [2*N_CH-1:0] PULL_I,
    input  logic [N_CH-1:0]   DB_EN_I,
    input  logic [DB_W-1:0]   DB_LIMIT_I,
    input  logic [2*N_CH-1:0] IRQ_EDGE_I,
    input  logic [N_CH-1:0]   IRQ_CLR_I,
    output logic [N_CH-1:0]   PAD_DO_O,
    output logic [N_CH-1:0]   PAD_OE_O,
    output logic [N_CH-1:0]   PAD_ODP_O,
    output logic [N_CH-1:0]   PAD_ODN_O,
    output logic [N_CH-1:0]   PAD_IE_O,
    output logic [N_CH-1:0]   PAD_PU_O,
    output logic [N_CH-1:0]   PAD_PD_O,
    input  logic [N_CH-1:0]   PAD_DI_I,
    output logic [N_CH-1:0]   DIN_O,
    output logic [N_CH-1:0]   IRQ_PEND_O,
    output logic              IRQ_O
);

    localparam logic [1:0]      MODE_IN = 2'b00;
    localparam logic [1:0]      MODE_OD = 2'b10;
    localparam logic [1:0]      MODE_OS = 2'b11;
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

    // Qualifies the first edge after reset release: mode and receive path start one edge later.
    logic armedQ;

    logic            dbBypass;
    logic [DB_W-1:0] limitM1;
    logic [N_CH-1:0] pendNext;

    assign dbBypass = (DB_LIMIT_I == '0);
    assign limitM1  = DB_LIMIT_I - DB_ONE;

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            armedQ     <= 1'b0;
            PAD_DO_O   <= '0;
            PAD_IE_O   <= '0;
            PAD_PU_O   <= '0;
            PAD_PD_O   <= '0;
            IRQ_PEND_O <= '0;
            IRQ_O      <= 1'b0;
        end else begin
            armedQ     <= 1'b1;
            PAD_DO_O   <= DOUT_I;
            PAD_IE_O   <= IE_EN_I;
            for (int i = 0; i < N_CH; i++) begin
                PAD_PU_O[i] <= PULL_I[2*i+1];
                PAD_PD_O[i] <= PULL_I[2*i];
            end
            IRQ_PEND_O <= pendNext;
            IRQ_O      <= |IRQ_PEND_O;
        end
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : gCh
        logic [1:0] modeNew;
        logic [1:0] modeQ, modeNext;
        logic       bbmQ, bbmNext;
        logic       oeQ, odpQ, odnQ;
        logic       oeNext, odpNext, odnNext;

        assign modeNew = MODE_I[2*ch +: 2];

        always_comb begin
            modeNext = modeQ;
            bbmNext  = 1'b0;
            oeNext   = oeQ;
            odpNext  = odpQ;
            odnNext  = odnQ;
            if (armedQ) begin
                // Driving-to-driving change: release the pad for one cycle, keep old ODP/ODN.
                if (!bbmQ && (modeNew != modeQ) && (modeQ != MODE_IN) && (modeNew != MODE_IN)) begin
                    bbmNext = 1'b1;
                    oeNext  = 1'b0;
                end else begin
                    modeNext = modeNew;
                    oeNext   = (modeNew != MODE_IN);
                    odpNext  = (modeNew == MODE_OD);
                    odnNext  = (modeNew == MODE_OS);
                end
            end
        end

        always_ff @(posedge CLK_I or negedge RST_NI) begin
            if (!RST_NI) begin
                modeQ <= MODE_IN;
                bbmQ  <= 1'b0;
                oeQ   <= 1'b0;
                odpQ  <= 1'b0;
                odnQ  <= 1'b0;
            end else begin
                modeQ <= modeNext;
                bbmQ  <= bbmNext;
                oeQ   <= oeNext;
                odpQ  <= odpNext;
                odnQ  <= odnNext;
            end
        end

        assign PAD_OE_O[ch]  = oeQ;
        assign PAD_ODP_O[ch] = odpQ;
        assign PAD_ODN_O[ch] = odnQ;

        logic [SYNC_STAGES-1:0] syncQ;
        logic                   syncOut;
        logic                   filtQ, filtNext;
        logic [DB_W-1:0]        cntQ, cntNext;
        logic                   riseHit, fallHit;

        assign syncOut = syncQ[SYNC_STAGES-1];

        always_comb begin
            filtNext = filtQ;
            cntNext  = cntQ;
            if (!IE_EN_I[ch]) begin
                filtNext = 1'b0;
                cntNext  = '0;
            end else if (!armedQ) begin
                filtNext = filtQ;
            end else if (!DB_EN_I[ch] || dbBypass) begin
                filtNext = syncOut;
                cntNext  = '0;
            end else if (syncOut == filtQ) begin
                cntNext = '0;
            end else if (cntQ == limitM1) begin
                filtNext = syncOut;
                cntNext  = '0;
            end else if (cntQ != '1) begin
                cntNext = cntQ + DB_ONE;
            end
        end

        always_ff @(posedge CLK_I or negedge RST_NI) begin
            if (!RST_NI) begin
                syncQ <= '0;
                filtQ <= 1'b0;
                cntQ  <= '0;
            end else begin
                if (!IE_EN_I[ch]) begin
                    syncQ <= '0;
                end else if (armedQ) begin
                    syncQ <= {syncQ[SYNC_STAGES-2:0], PAD_DI_I[ch]};
                end
                filtQ <= filtNext;
                cntQ  <= cntNext;
            end
        end

        // The forced-low value while the receiver is off never counts as an edge.
        assign riseHit = IE_EN_I[ch] & filtNext & ~filtQ & IRQ_EDGE_I[2*ch];
        assign fallHit = IE_EN_I[ch] & ~filtNext & filtQ & IRQ_EDGE_I[2*ch+1];

        assign pendNext[ch] = (IRQ_PEND_O[ch] & ~IRQ_CLR_I[ch]) | riseHit | fallHit;
        assign DIN_O[ch]    = filtQ;
    end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed bench for gpio_pad_ctrl: drive modes, receive filtering, interrupts and reset.
module tb_gpio_pad_ctrl;
    localparam int N_CH        = 8;
    localparam int SYNC_STAGES = 2;
    localparam int DB_W        = 8;

    logic                clk = 1'b0;
    logic                rstN = 1'b1;
    logic [2*N_CH-1:0]   modeI = '0;
    logic [2*N_CH-1:0]   pullI = '0;
    logic [2*N_CH-1:0]   irqEdgeI = '0;
    logic [N_CH-1:0]     doutI = '0;
    logic [N_CH-1:0]     ieEnI = '0;
    logic [N_CH-1:0]     dbEnI = '0;
    logic [N_CH-1:0]     irqClrI = '0;
    logic [N_CH-1:0]     padDiI = '0;
    logic [DB_W-1:0]     dbLimitI = 8'd4;
    logic [N_CH-1:0]     padDo, padOe, padOdp, padOdn, padIe, padPu, padPd, din, irqPend;
    logic                irq;
    int                  checks = 0;
    int                  passed = 0;

    always #5 clk = ~clk;

    gpio_pad_ctrl #(.N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .DB_W(DB_W)) dut (
        .CLK_I(clk), .RST_NI(rstN), .MODE_I(modeI), .DOUT_I(doutI), .IE_EN_I(ieEnI),
        .PULL_I(pullI), .DB_EN_I(dbEnI), .DB_LIMIT_I(dbLimitI), .IRQ_EDGE_I(irqEdgeI),
        .IRQ_CLR_I(irqClrI), .PAD_DO_O(padDo), .PAD_OE_O(padOe), .PAD_ODP_O(padOdp),
        .PAD_ODN_O(padOdn), .PAD_IE_O(padIe), .PAD_PU_O(padPu), .PAD_PD_O(padPd),
        .PAD_DI_I(padDiI), .DIN_O(din), .IRQ_PEND_O(irqPend), .IRQ_O(irq)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rstN = 1'b0;
        modeI = 16'h0080;
        doutI = 8'hFF;
        step(2);
        checks++; if (padOe !== 8'h00) $display("FAIL rst_oe: got %h want 00", padOe); else passed++;
        checks++; if (padDo !== 8'h00) $display("FAIL rst_do: got %h want 00", padDo); else passed++;
        checks++; if (din !== 8'h00) $display("FAIL rst_din: got %h want 00", din); else passed++;
        checks++; if (irqPend !== 8'h00) $display("FAIL rst_pend: got %h want 00", irqPend); else passed++;
        checks++; if (irq !== 1'b0) $display("FAIL rst_irq: got %b want 0", irq); else passed++;
        rstN = 1'b1;
        step(1);
        checks++; if (padOe[3] !== 1'b0) $display("FAIL rel_oe_edge1: got %b want 0", padOe[3]); else passed++;
        checks++; if (padDo !== 8'hFF) $display("FAIL rel_do: got %h want ff", padDo); else passed++;
        step(1);
        checks++; if ({padOe[3], padOdp[3], padOdn[3]} !== 3'b110)
            $display("FAIL rel_od_edge2: got %b want 110", {padOe[3], padOdp[3], padOdn[3]}); else passed++;
    endtask

    task automatic test_push_pull();
        doutI = 8'h01;
        modeI[1:0] = 2'b01;
        step(1);
        checks++; if ({padOe[0], padOdp[0], padOdn[0]} !== 3'b100)
            $display("FAIL pp_ctrl: got %b want 100", {padOe[0], padOdp[0], padOdn[0]}); else passed++;
        checks++; if (padDo !== 8'h01) $display("FAIL pp_do: got %h want 01", padDo); else passed++;
    endtask

    task automatic test_break_before_make();
        modeI[3:2] = 2'b01;
        step(1);
        checks++; if (padOe[1] !== 1'b1) $display("FAIL bbm_pp_oe: got %b want 1", padOe[1]); else passed++;
        modeI[3:2] = 2'b10;
        step(1);
        checks++; if ({padOe[1], padOdp[1]} !== 2'b00)
            $display("FAIL bbm_gap: got %b want 00", {padOe[1], padOdp[1]}); else passed++;
        step(1);
        checks++; if ({padOe[1], padOdp[1]} !== 2'b11)
            $display("FAIL bbm_od: got %b want 11", {padOe[1], padOdp[1]}); else passed++;
        step(1);
        checks++; if (padOe[1] !== 1'b1) $display("FAIL bbm_hold: got %b want 1", padOe[1]); else passed++;
        modeI[3:2] = 2'b00;
        step(1);
        checks++; if ({padOe[1], padOdp[1]} !== 2'b00)
            $display("FAIL to_input: got %b want 00", {padOe[1], padOdp[1]}); else passed++;
        modeI[1:0] = 2'b11;
        step(1);
        checks++; if (padOe[0] !== 1'b0) $display("FAIL bbm_os_gap: got %b want 0", padOe[0]); else passed++;
        step(1);
        checks++; if ({padOe[0], padOdp[0], padOdn[0]} !== 3'b101)
            $display("FAIL bbm_os: got %b want 101", {padOe[0], padOdp[0], padOdn[0]}); else passed++;
    endtask

    task automatic test_pad_pass();
        ieEnI = 8'hA5;
        pullI = 16'h9C36;
        step(1);
        checks++; if (padIe !== 8'hA5) $display("FAIL ie_pass: got %h want a5", padIe); else passed++;
        checks++; if (padPu !== 8'hA5) $display("FAIL pu_mixed: got %h want a5", padPu); else passed++;
        checks++; if (padPd !== 8'h66) $display("FAIL pd_mixed: got %h want 66", padPd); else passed++;
        ieEnI = 8'hFF;
        pullI = 16'hAAAA;
        step(1);
        checks++; if ({padPu, padPd} !== 16'hFF00) $display("FAIL pull_pu_all: got %h want ff00", {padPu, padPd}); else passed++;
    endtask

    task automatic test_debounce();
        dbEnI = 8'h10;
        dbLimitI = 8'd4;
        padDiI[4] = 1'b1;
        step(3);
        padDiI[4] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1);
            checks++; if (din[4] !== 1'b0) $display("FAIL db_glitch cyc%0d: got %b want 0", k, din[4]); else passed++;
        end
        padDiI[4] = 1'b1;
        for (int k = 1; k <= SYNC_STAGES + 4; k++) begin
            step(1);
            if (k == SYNC_STAGES + 3) begin
                checks++; if (din[4] !== 1'b0) $display("FAIL db_early: got %b want 0", din[4]); else passed++;
            end
            if (k == SYNC_STAGES + 4) begin
                checks++; if (din[4] !== 1'b1) $display("FAIL db_accept: got %b want 1", din[4]); else passed++;
            end
        end
        padDiI[4] = 1'b0;
        step(SYNC_STAGES + 5);
        checks++; if (din[4] !== 1'b0) $display("FAIL db_fall: got %b want 0", din[4]); else passed++;
        padDiI[5] = 1'b1;
        step(2);
        checks++; if (din[5] !== 1'b0) $display("FAIL nodb_early: got %b want 0", din[5]); else passed++;
        step(1);
        checks++; if (din[5] !== 1'b1) $display("FAIL nodb_copy: got %b want 1", din[5]); else passed++;
        dbEnI[7] = 1'b1;
        dbLimitI = 8'd0;
        padDiI[7] = 1'b1;
        step(2);
        checks++; if (din[7] !== 1'b0) $display("FAIL lim0_early: got %b want 0", din[7]); else passed++;
        step(1);
        checks++; if (din[7] !== 1'b1) $display("FAIL lim0_copy: got %b want 1", din[7]); else passed++;
        dbLimitI = 8'd4;
        checks++; if (irqPend !== 8'h00) $display("FAIL db_no_irq: got %h want 00", irqPend); else passed++;
    endtask

    task automatic test_irq();
        irqEdgeI = 16'h0010;
        padDiI[2] = 1'b1;
        step(2);
        checks++; if (irqPend !== 8'h00) $display("FAIL irq_early: got %h want 00", irqPend); else passed++;
        step(1);
        checks++; if ({din[2], irqPend, irq} !== {1'b1, 8'h04, 1'b0})
            $display("FAIL irq_rise: got din=%b pend=%h irq=%b want 1 04 0", din[2], irqPend, irq); else passed++;
        step(1);
        checks++; if (irq !== 1'b1) $display("FAIL irq_out: got %b want 1", irq); else passed++;
        padDiI[2] = 1'b0;
        step(3);
        checks++; if ({din[2], irqPend} !== {1'b0, 8'h04})
            $display("FAIL irq_fall_off: got din=%b pend=%h want 0 04", din[2], irqPend); else passed++;
        padDiI[2] = 1'b1;
        step(2);
        irqClrI = 8'h04;
        step(1);
        irqClrI = 8'h00;
        checks++; if ({din[2], irqPend} !== {1'b1, 8'h04})
            $display("FAIL irq_set_prio: got din=%b pend=%h want 1 04", din[2], irqPend); else passed++;
        irqClrI = 8'h04;
        step(1);
        irqClrI = 8'h00;
        checks++; if (irqPend !== 8'h00) $display("FAIL irq_clear: got %h want 00", irqPend); else passed++;
        step(1);
        checks++; if (irq !== 1'b0) $display("FAIL irq_out_clr: got %b want 0", irq); else passed++;
        irqEdgeI = 16'h0000;
        padDiI[2] = 1'b0;
        step(3);
        irqEdgeI = 16'h0020;
        step(2);
        checks++; if ({din[2], irqPend} !== {1'b0, 8'h00})
            $display("FAIL irq_no_latch: got din=%b pend=%h want 0 00", din[2], irqPend); else passed++;
        padDiI[2] = 1'b1;
        step(3);
        padDiI[2] = 1'b0;
        step(3);
        checks++; if (irqPend !== 8'h04) $display("FAIL irq_fall: got %h want 04", irqPend); else passed++;
        irqEdgeI = 16'h0000;
        irqClrI = 8'h04;
        step(1);
        irqClrI = 8'h00;
        step(1);
    endtask

    task automatic test_ie_force();
        irqEdgeI = 16'h2000;
        padDiI[6] = 1'b1;
        step(3);
        checks++; if ({din[6], irqPend} !== {1'b1, 8'h00})
            $display("FAIL ie_pre: got din=%b pend=%h want 1 00", din[6], irqPend); else passed++;
        ieEnI[6] = 1'b0;
        step(1);
        checks++; if ({din[6], padIe[6], irqPend} !== {2'b00, 8'h00})
            $display("FAIL ie_force: got din=%b ie=%b pend=%h want 0 0 00", din[6], padIe[6], irqPend); else passed++;
        step(2);
        checks++; if (irqPend !== 8'h00) $display("FAIL ie_no_fall: got %h want 00", irqPend); else passed++;
        ieEnI[6] = 1'b1;
        irqEdgeI = 16'h0000;
        step(SYNC_STAGES + 1);
        checks++; if (din[6] !== 1'b1) $display("FAIL ie_reenable: got %b want 1", din[6]); else passed++;
    endtask

    task automatic test_reset_mid_debounce();
        padDiI[4] = 1'b1;
        step(4);
        checks++; if (din[4] !== 1'b0) $display("FAIL mid_pre: got %b want 0", din[4]); else passed++;
        #2 rstN = 1'b0;
        #1;
        checks++; if ({din, padOe, padDo, padIe, padPu, irqPend, irq} !== 49'd0)
            $display("FAIL mid_async: din=%h oe=%h do=%h ie=%h pu=%h pend=%h irq=%b want all 0",
                     din, padOe, padDo, padIe, padPu, irqPend, irq); else passed++;
        @(negedge clk);
        rstN = 1'b1;
        for (int k = 1; k <= SYNC_STAGES + 5; k++) begin
            step(1);
            if (k == SYNC_STAGES + 1) begin
                checks++; if (din[5] !== 1'b0) $display("FAIL post_nodb_early: got %b want 0", din[5]); else passed++;
            end
            if (k == SYNC_STAGES + 2) begin
                checks++; if (din[5] !== 1'b1) $display("FAIL post_nodb: got %b want 1", din[5]); else passed++;
            end
            if (k == SYNC_STAGES + 4) begin
                checks++; if (din[4] !== 1'b0) $display("FAIL post_db_stale: got %b want 0", din[4]); else passed++;
            end
            if (k == SYNC_STAGES + 5) begin
                checks++; if (din[4] !== 1'b1) $display("FAIL post_db: got %b want 1", din[4]); else passed++;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_push_pull();
        test_break_before_make();
        test_pad_pass();
        test_debounce();
        test_irq();
        test_ie_force();
        test_reset_mid_debounce();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
